// File: rtl/ysyx_22050058_div.sv
// Multi-cycle RV64M divider (div/divu/rem/remu and word forms) for the EX stage.
// Restoring radix-2, 64 iterations; divide-by-zero and signed overflow finish in one cycle.
module ysyx_22050058_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start_i,
  input  logic        div_signed_i,
  input  logic        div_rem_i,
  input  logic        div_word_i,
  input  logic [63:0] div_dividend_i,
  input  logic [63:0] div_divisor_i,
  input  logic        div_flush_i,
  input  logic        div_hold_i,
  output logic        div_stall_req_o,
  output logic        div_ready_o,
  output logic [63:0] div_result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [63:0] sext_word(input logic [63:0] v, input logic word);
    if (word) begin
      sext_word = {{32{v[31]}}, v[31:0]};
    end else begin
      sext_word = v;
    end
  endfunction

  state_t       r_state;
  logic [6:0]   r_cnt;
  logic [127:0] r_pr;
  logic [63:0]  r_dvs;
  logic         r_q_neg;
  logic         r_r_neg;
  logic         r_rem;
  logic         r_word;
  logic         r_ready;
  logic [63:0]  r_result;

  logic [63:0]  w_a_ext;
  logic [63:0]  w_b_ext;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [63:0]  w_a_mag;
  logic [63:0]  w_b_mag;
  logic         w_div_zero;
  logic         w_ovf;
  logic [63:0]  w_special_raw;
  logic [63:0]  w_special_res;
  logic [128:0] w_shift;
  logic [64:0]  w_diff;
  logic [127:0] w_pr_next;
  logic [63:0]  w_q_fix;
  logic [63:0]  w_r_fix;
  logic [63:0]  w_busy_res;

  // Operand preparation: width extension, magnitudes and special-case detection.
  always_comb begin
    w_a_ext = div_dividend_i;
    w_b_ext = div_divisor_i;
    if (div_word_i) begin
      if (div_signed_i) begin
        w_a_ext = {{32{div_dividend_i[31]}}, div_dividend_i[31:0]};
        w_b_ext = {{32{div_divisor_i[31]}}, div_divisor_i[31:0]};
      end else begin
        w_a_ext = {32'd0, div_dividend_i[31:0]};
        w_b_ext = {32'd0, div_divisor_i[31:0]};
      end
    end else begin
      w_a_ext = div_dividend_i;
      w_b_ext = div_divisor_i;
    end
    w_a_neg    = div_signed_i & w_a_ext[63];
    w_b_neg    = div_signed_i & w_b_ext[63];
    w_a_mag    = w_a_neg ? (64'd0 - w_a_ext) : w_a_ext;
    w_b_mag    = w_b_neg ? (64'd0 - w_b_ext) : w_b_ext;
    w_div_zero = (w_b_ext == 64'd0);
    // Most-negative value at the operation width, already sign-extended for word forms.
    w_ovf      = div_signed_i & (w_b_ext == 64'hFFFF_FFFF_FFFF_FFFF) &
                 (w_a_ext == (div_word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    if (w_div_zero) begin
      w_special_raw = div_rem_i ? w_a_ext : 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      w_special_raw = div_rem_i ? 64'd0 : w_a_ext;
    end
    w_special_res = sext_word(w_special_raw, div_word_i);
  end

  // One restoring step plus sign correction of the final quotient/remainder.
  always_comb begin
    w_shift = {r_pr, 1'b0};
    w_diff  = w_shift[128:64] - {1'b0, r_dvs};
    if (!w_diff[64]) begin
      w_pr_next = {w_diff[63:0], w_shift[63:1], 1'b1};
    end else begin
      w_pr_next = w_shift[127:0];
    end
    w_q_fix    = r_q_neg ? (64'd0 - w_pr_next[63:0])   : w_pr_next[63:0];
    w_r_fix    = r_r_neg ? (64'd0 - w_pr_next[127:64]) : w_pr_next[127:64];
    w_busy_res = sext_word(r_rem ? w_r_fix : w_q_fix, r_word);
  end

  assign div_stall_req_o = div_start_i & (r_state != S_DONE) & ~div_flush_i;
  assign div_ready_o     = r_ready;
  assign div_result_o    = r_result;

  // Control FSM, iteration datapath and registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 7'd0;
      r_pr     <= 128'd0;
      r_dvs    <= 64'd0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_rem    <= 1'b0;
      r_word   <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= 64'd0;
    end else if (div_flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 7'd0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_start_i) begin
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
            r_rem   <= div_rem_i;
            r_word  <= div_word_i;
            r_cnt   <= 7'd0;
            if (w_div_zero | w_ovf) begin
              r_result <= w_special_res;
              r_ready  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_pr    <= {64'd0, w_a_mag};
              r_dvs   <= w_b_mag;
              r_state <= S_BUSY;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_pr <= w_pr_next;
          if (r_cnt == 7'd63) begin
            r_cnt    <= 7'd0;
            r_result <= w_busy_res;
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_DONE: begin
          if (!div_hold_i) begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_cnt   <= 7'd0;
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050058_div.sv
// Scoreboard bench for ysyx_22050058_div: plan vectors, random vectors against a
// reference model, latency/stall counts, flush, hold, back-to-back and async reset.
module tb_ysyx_22050058_div;

  logic        clk;
  logic        rst;
  logic        div_start_i;
  logic        div_signed_i;
  logic        div_rem_i;
  logic        div_word_i;
  logic [63:0] div_dividend_i;
  logic [63:0] div_divisor_i;
  logic        div_flush_i;
  logic        div_hold_i;
  logic        div_stall_req_o;
  logic        div_ready_o;
  logic [63:0] div_result_o;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  ysyx_22050058_div dut (
    .clk            (clk),
    .rst            (rst),
    .div_start_i    (div_start_i),
    .div_signed_i   (div_signed_i),
    .div_rem_i      (div_rem_i),
    .div_word_i     (div_word_i),
    .div_dividend_i (div_dividend_i),
    .div_divisor_i  (div_divisor_i),
    .div_flush_i    (div_flush_i),
    .div_hold_i     (div_hold_i),
    .div_stall_req_o(div_stall_req_o),
    .div_ready_o    (div_ready_o),
    .div_result_o   (div_result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic sg, input logic rm, input logic wd);
    logic [31:0] a32, b32, q32, r32, x32;
    logic [63:0] q, r;
    if (wd) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (sg) begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      x32 = rm ? r32 : q32;
      return {{32{x32[31]}}, x32};
    end
    if (b == 64'd0) begin
      q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
    end else if (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = a; r = 64'd0;
    end else if (sg) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return rm ? r : q;
  endfunction

  function automatic int exp_latency(input logic [63:0] a, input logic [63:0] b,
                                     input logic sg, input logic wd);
    if (wd) begin
      if (b[31:0] == 32'd0) return 1;
      if (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 65;
    end
    if (b == 64'd0) return 1;
    if (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
    return 65;
  endfunction

  // Entered at posedge+1; returns at posedge+1 of the cycle after DONE is left.
  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic sg, input logic rm, input logic wd,
                        input logic [63:0] exp, input int hold_n);
    int lat, stalls;
    bit got;
    logic [63:0] want;
    lat = exp_latency(a, b, sg, wd);
    div_dividend_i = a; div_divisor_i = b;
    div_signed_i = sg; div_rem_i = rm; div_word_i = wd;
    div_start_i = 1'b1;
    sb.push_back(exp);
    stalls = 0; got = 1'b0; want = 64'd0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (div_stall_req_o) stalls++;
      if (div_ready_o) begin
        got = 1'b1;
        want = sb.pop_front();
        n_vec++;
        if (div_result_o !== want) begin
          n_err++;
          $display("FAIL %s result: got %h expected %h", name, div_result_o, want);
        end
        n_vec++;
        if (k != lat) begin
          n_err++;
          $display("FAIL %s latency: got %0d expected %0d", name, k, lat);
        end
        n_vec++;
        if (stalls != lat) begin
          n_err++;
          $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, lat);
        end
      end else begin
        if (k > 0) begin
          div_dividend_i = {$urandom(), $urandom()};
          div_divisor_i  = {$urandom(), $urandom()};
        end
        @(posedge clk) #1;
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: got no ready expected ready at %0d", name, lat);
      void'(sb.pop_front());
    end
    if (got && hold_n > 0) begin
      div_hold_i = 1'b1;
      for (int h = 0; h < hold_n; h++) begin
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (div_ready_o !== 1'b1 || div_result_o !== want) begin
          n_err++;
          $display("FAIL %s hold_stable: got ready=%b result=%h expected ready=1 result=%h",
                   name, div_ready_o, div_result_o, want);
        end
      end
      div_hold_i = 1'b0;
    end
    @(posedge clk) #1;
    div_start_i = 1'b0;
    if (hold_n > 0) begin
      @(negedge clk);
      n_vec++;
      if (div_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle_after_hold: got ready=%b expected 0", name, div_ready_o);
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; div_start_i = 1'b0; div_signed_i = 1'b0; div_rem_i = 1'b0;
    div_word_i = 1'b0; div_dividend_i = 64'd0; div_divisor_i = 64'd0;
    div_flush_i = 1'b0; div_hold_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (div_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", div_ready_o); end
    n_vec++;
    if (div_result_o !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", div_result_o); end
    n_vec++;
    if (div_stall_req_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", div_stall_req_o); end
    @(posedge clk) #1;
  endtask

  task automatic test_unsigned();
    run_op("divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 0);
    run_op("remu_100_7", 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd2, 0);
  endtask

  task automatic test_signed();
    run_op("div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("rem_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
  endtask

  task automatic test_special();
    run_op("div_by0", 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("rem_by0", 64'd5, 64'd0, 1'b1, 1'b1, 1'b0, 64'd5, 0);
    run_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 0);
    run_op("rem_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'd0, 0);
  endtask

  task automatic test_word();
    run_op("divuw", 64'hDEAD_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b1,
           64'hFFFF_FFFF_8000_0000, 0);
    run_op("remw_by0", 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1, 1'b1,
           64'hFFFF_FFFF_9ABC_DEF0, 0);
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    logic sg, rm, wd;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      if (i % 3 == 0) b = b >> 40;
      if (i == 5) b = 64'd0;
      sg = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      run_op("random", a, b, sg, rm, wd, ref_div(a, b, sg, rm, wd), 0);
    end
  endtask

  task automatic test_flush();
    bit bad;
    bad = 1'b0;
    div_dividend_i = 64'd1000; div_divisor_i = 64'd3;
    div_signed_i = 1'b0; div_rem_i = 1'b0; div_word_i = 1'b0;
    div_start_i = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k == 20) div_flush_i = 1'b1;
      @(negedge clk);
      if (div_ready_o) bad = 1'b1;
      if (k == 20) begin
        n_vec++;
        if (div_stall_req_o !== 1'b0) begin
          n_err++; $display("FAIL flush_stall: got %b expected 0", div_stall_req_o);
        end
      end
      @(posedge clk) #1;
    end
    div_flush_i = 1'b0; div_start_i = 1'b0;
    @(negedge clk);
    if (div_ready_o) bad = 1'b1;
    n_vec++;
    if (bad) begin n_err++; $display("FAIL flush_no_ready: got ready=1 expected 0"); end
    @(posedge clk) #1;
    run_op("after_flush", 64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 64'd333, 0);
  endtask

  task automatic test_hold();
    run_op("hold3", 64'd77, 64'd5, 1'b1, 1'b1, 1'b0, 64'd2, 3);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_a", 64'hFFFF_FFFF_FFFF_FF00, 64'd16, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 0);
    run_op("b2b_b", 64'd123456789, 64'd1000, 1'b0, 1'b1, 1'b0, 64'd789, 0);
  endtask

  task automatic test_async_reset();
    bit bad;
    bad = 1'b0;
    div_dividend_i = 64'd999; div_divisor_i = 64'd4;
    div_signed_i = 1'b0; div_rem_i = 1'b0; div_word_i = 1'b0;
    div_start_i = 1'b1;
    repeat (30) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_vec++;
    if (div_ready_o !== 1'b0 || div_result_o !== 64'd0) begin
      n_err++;
      $display("FAIL async_reset: got ready=%b result=%h expected ready=0 result=0",
               div_ready_o, div_result_o);
    end
    @(posedge clk) #1;
    rst = 1'b1; div_start_i = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (div_ready_o) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin n_err++; $display("FAIL reset_no_result: got ready=1 expected 0"); end
    @(posedge clk) #1;
    run_op("after_reset", 64'd999, 64'd4, 1'b0, 1'b0, 1'b0, 64'd249, 0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_word();
    test_random();
    test_flush();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22050058_div.md
# ysyx_22050058_div

Multi-cycle RV64M divider in the EX stage of the ysyx_22050058 five-stage pipeline. It covers div/divu/rem/remu and the word forms divw/divuw/remw/remuw. While an operation is in flight it asserts the EX stall request to the pipeline controller. It honours the controller's flush and downstream stall so that an aborted or held instruction is handled correctly.

## Interface
No parameters (XLEN fixed at 64).
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- div_start_i  input  1  EX holds a divide instruction; held high with stable operands while EX is stalled
- div_signed_i  input  1  1 = div/rem/divw/remw, 0 = unsigned forms
- div_rem_i  input  1  1 = return remainder, 0 = return quotient
- div_word_i  input  1  1 = *w form (32-bit operation, 64-bit sign-extended result)
- div_dividend_i  input  64  rs1 value
- div_divisor_i  input  64  rs2 value
- div_flush_i  input  1  EX-stage flush bit from the controller; aborts the operation
- div_hold_i  input  1  stall from a later stage (MEM request); result must be held
- div_stall_req_o  output  1  EX stall request to the controller
- div_ready_o  output  1  div_result_o valid this cycle
- div_result_o  output  64  quotient or remainder

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE, 7-bit counter = 0, div_result_o = 0, div_ready_o = 0.
- Operand prep in IDLE on div_start_i:
  - Word forms use a[31:0] and b[31:0], sign-extended if signed, else zero-extended to 64.
  - Signed forms take magnitudes.
  - Latch q_neg = sign(a) ^ sign(b) and r_neg = sign(a).
- Special cases go IDLE → DONE directly, with no iteration:
  - Divisor zero (low 32 bits for word forms): quotient = all ones; remainder = prepared dividend.
  - Signed overflow (a = most-negative, b = −1, at the operation width): quotient = a; remainder = 0.
- Normal case goes IDLE → BUSY. Restoring radix-2 with a 128-bit partial remainder, one quotient bit per cycle, always 64 iterations; the counter counts 0..63.
- Exit: last iteration → DONE. Apply sign correction (two's complement of quotient if q_neg, of remainder if r_neg) when registering the result.
- Word-form result = sign-extension of bit 31 of the 32-bit result. This applies to divuw/remuw as well.
- Leaving DONE:
  - DONE → IDLE when div_hold_i = 0.
  - DONE stays DONE, with result and div_ready_o stable, while div_hold_i = 1.
- div_ready_o = 1 exactly in DONE.
- div_stall_req_o = div_start_i & (state != DONE) & ~div_flush_i (combinational).
- Flush: div_flush_i = 1 in any state → IDLE next edge and counter cleared. div_ready_o is not asserted for the aborted operation.
- A start seen in IDLE in the cycle after DONE is a new instruction. Back-to-back divides are legal.
- Operands are sampled only in IDLE. Changes on div_dividend_i/div_divisor_i during BUSY are ignored.

## Timing
- Normal path, with start first seen in IDLE at cycle T:
  - BUSY for cycles T+1..T+64.
  - DONE at T+65.
  - div_stall_req_o = 1 for T..T+64 (65 cycles) and 0 at T+65, when the instruction advances with the result.
- Special-case path: stall_req = 1 at T only; DONE at T+1.
- Flush has priority over hold and over start.
- rst low mid-operation: all state clears immediately (asynchronous), outputs drop to their reset values, and no result is produced.
- With div_start_i = 0: stall_req = 0, state stays IDLE.

## Test plan
- divu: a = 100, b = 7 → ready at T+65, result 14; rem form gives 2; stall_req high for exactly 65 cycles.
- div signed: a = −7 (0xFFFF_FFFF_FFFF_FFF9), b = 2 → quotient 0xFFFF_FFFF_FFFF_FFFD (−3); rem → 0xFFFF_FFFF_FFFF_FFFF (−1).
- Special cases, each ready at T+1:
  - Divide by zero: a = 5, b = 0 → quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5.
  - Overflow: a = 0x8000_0000_0000_0000, b = −1 → quotient 0x8000_0000_0000_0000, remainder 0.
- Word forms:
  - divuw a = 0xDEAD_0000_FFFF_FFFE, b = 1 → 0xFFFF_FFFF_FFFF_FFFE.
  - divw a = 0x8000_0000, b = 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
  - remw by zero → sext(a[31:0]).
- Flush at T+20 → IDLE at T+21, ready never asserts; a new start at T+22 completes normally at T+87.
- Hold and reset:
  - div_hold_i = 1 for 3 cycles while in DONE → result and ready stay stable 4 cycles total, then IDLE.
  - Back-to-back divides each take full latency.
  - rst pulsed low at T+30 → outputs 0 asynchronously.
